battleship_engine: RTL
======================

# battleship_engine

Parametrised successor of the single-grid battleship top level. It holds both GRID×GRID boards as 2-bit cell vectors and runs the full match sequence in one clocked FSM: player ship placement, alternating player and PC shots, a per-turn timer, and win/lose detection. The PC shoots from an LFSR with a linear-probe fallback. It sits below the board-display and button-conditioning logic: buttons arrive here already debounced as single-cycle active-high strobes.

## Interface
Parameters:
- GRID, 5: board edge length, 2..8; N = GRID*GRID cells.
- MAX_SHIPS, 3: maximum player ships, 1..N; each ship is one cell.
- PC_LAYOUT, 25'h0000C40: N-bit PC ship mask, bit idx = cell idx.
- TIMEOUT_CYCLES, 50_000_000: player-turn limit in clk cycles (≥2).
- LFSR_SEED, 8'hA5: nonzero seed of the 8-bit PC-target LFSR.

Ports (W = $clog2(GRID), H = $clog2(N+1)):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- izquierda, derecha, arriba, abajo  in  1 each  cursor-move strobes.
- poner  in  1  place-ship strobe.
- attack  in  1  fire-at-cursor strobe.
- barcos  in  $clog2(MAX_SHIPS+1)  requested player ship count.
- cursor_x, cursor_y  out  W  player cursor.
- pc_shot_x, pc_shot_y  out  W  last PC target.
- matriz_player, matriz_pc  out  2*N  boards; cell idx = y*GRID+x at bits [2*idx+1:2*idx]; 0 empty, 1 ship, 2 hit, 3 miss.
- hp_player, hp_pc  out  H  remaining ship cells.
- estado  out  3  FSM state code.
- win, lose  out  1  match result, held.
- turn_timer  out  32  cycles left in the player turn.

## Operation
- States and codes: PLACE=0, PLAYER=1, PC=2, WIN=3, LOSE=4.
- Reset (async assert, sync-released use): estado=PLACE; cursor=(0,0); pc_shot=(0,0); matriz_player all 0; matriz_pc = 1 where PC_LAYOUT bit set, else 0; hp_player=0; hp_pc=popcount(PC_LAYOUT); win=lose=0; turn_timer=0; LFSR=LFSR_SEED.
- Cursor, in PLACE and PLAYER only: one move per cycle, priority izquierda > derecha > arriba > abajo. Moves wrap around: x=0 with izquierda gives GRID-1, and x=GRID-1 with derecha gives 0; y wraps the same way. arriba decrements y.
- Target count T = barcos clamped to 1..MAX_SHIPS, sampled on every poner.
- PLACE: poner on an empty cell writes 1 and increments hp_player. poner on an occupied cell is ignored. When hp_player reaches T, go to PLAYER and load turn_timer = TIMEOUT_CYCLES.
- PLAYER: attack at the cursor (pre-move position). A move strobe in the same cycle is dropped.
  - Cell 1: write 2, decrement hp_pc. If hp_pc becomes 0, go to WIN; otherwise go to PC.
  - Cell 0: write 3, go to PC.
  - Cell 2 or 3: ignored, stay in PLAYER, timer keeps running.
- PC:
  - Candidate = LFSR mod N. The LFSR advances (taps 8,6,5,4) once on PC entry.
  - If the candidate cell is 2 or 3, probe idx+1 mod N on the next cycle, one cell per cycle.
  - On the first unattacked cell, apply the shot the same way (1→2 with hp_player decrement, 0→3) and update pc_shot.
  - If hp_player becomes 0, go to LOSE; otherwise go to PLAYER and reload the timer.
  - No unattacked cells left in PC state: go to WIN.
- WIN/LOSE: win or lose is held at 1, all inputs are ignored, exit only via reset.
- An active-low reset mid-match aborts it immediately with the reset values above.
- Arithmetic: hp counters never underflow. Decrement only on a 1→2 transition.

## Timing
- Strobe at cycle t: board, hp, cursor and estado update at t+1.
- PC shot latency: 1 cycle after PC entry, plus 1 per occupied probe. Worst case N cycles.
- turn_timer decrements every PLAYER cycle. At 1 with no valid attack, the next cycle goes to PC with no player shot (forfeit).
- A valid attack in the same cycle the timer hits 1 takes effect; it is not a forfeit.
- Outputs are registered; no combinational input-to-output paths.

## Configuration
- BATTLESHIP_TIMEOUT_EN defined: the turn timer and forfeit behave as above.
- Undefined: the timer logic is removed, turn_timer is tied to 0, and PLAYER waits indefinitely.

## Test plan
- Reset with default params → matriz_pc cells 10,11,6 = 1 (mask 25'h0000C40: bits 6,10,11); hp_pc=3; estado=0; cursor (0,0).
- barcos=2, poner at (0,0) twice → second is ignored, hp_player=1. Then derecha, poner → hp_player=2 and estado=1 next cycle.
- izquierda at x=0 → x=4. Simultaneous izquierda+abajo → only x changes.
- Attack cells 6,10,11 across three player turns, with PC turns in between → matriz_pc cells = 2, hp_pc=0, estado=3, win=1. Further strobes change nothing.
- TIMEOUT_CYCLES=4, no attack in PLAYER → estado=2 after 4 cycles, matriz_pc unchanged. With the macro undefined, the bench stays in PLAYER for 1000 cycles.
- PC with all but one player-board cell pre-attacked → it probes linearly, hits the last free cell within 25 cycles, and pc_shot matches that cell.

Source files
------------

// File: rtl/battleship_engine.sv
// -----------------------------------------------------------------------------
// battleship_engine
//
// Match engine for a GRID x GRID battleship game. Both boards are held as
// packed 2-bit cell vectors (0 empty, 1 ship, 2 hit, 3 miss; cell
// idx = y*GRID + x at bits [2*idx+1:2*idx]). One clocked FSM runs the match:
// player ship placement, alternating player / PC shots, and win / lose
// detection. The PC picks a target from an 8-bit LFSR and walks linearly to
// the next unattacked cell when the pick has already been shot.
//
// Optional feature macro: BATTLESHIP_TIMEOUT_EN
//   defined   : per-turn player timer; reaching the end of the turn forfeits
//               the player's shot and hands the turn to the PC.
//   undefined : no timer, turn_timer reads 0, PLAYER waits indefinitely.
//
// Ports:
//   clk                          system clock
//   reset                        asynchronous, active-low reset
//   izquierda/derecha/arriba/abajo  cursor-move strobes (single cycle)
//   poner                        place-ship strobe
//   attack                       fire-at-cursor strobe
//   barcos                       requested player ship count
//   cursor_x, cursor_y           player cursor
//   pc_shot_x, pc_shot_y         last PC target
//   matriz_player, matriz_pc     board contents
//   hp_player, hp_pc             remaining ship cells
//   estado                       FSM state code (PLACE=0 PLAYER=1 PC=2 WIN=3 LOSE=4)
//   win, lose                    held match result
//   turn_timer                   cycles left in the player turn
// -----------------------------------------------------------------------------
module battleship_engine #(
    parameter int                   GRID           = 5,
    parameter int                   MAX_SHIPS      = 3,
    parameter logic [GRID*GRID-1:0] PC_LAYOUT      = 25'h0000C40,
    parameter int                   TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]           LFSR_SEED      = 8'hA5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               izquierda,
    input  logic                               derecha,
    input  logic                               arriba,
    input  logic                               abajo,
    input  logic                               poner,
    input  logic                               attack,
    input  logic [$clog2(MAX_SHIPS+1)-1:0]     barcos,
    output logic [$clog2(GRID)-1:0]            cursor_x,
    output logic [$clog2(GRID)-1:0]            cursor_y,
    output logic [$clog2(GRID)-1:0]            pc_shot_x,
    output logic [$clog2(GRID)-1:0]            pc_shot_y,
    output logic [2*GRID*GRID-1:0]             matriz_player,
    output logic [2*GRID*GRID-1:0]             matriz_pc,
    output logic [$clog2(GRID*GRID+1)-1:0]     hp_player,
    output logic [$clog2(GRID*GRID+1)-1:0]     hp_pc,
    output logic [2:0]                         estado,
    output logic                               win,
    output logic                               lose,
    output logic [31:0]                        turn_timer
);

    localparam int N  = GRID * GRID;
    localparam int W  = $clog2(GRID);
    localparam int IW = $clog2(N);
    localparam int H  = $clog2(N + 1);

    localparam logic [2:0] ST_PLACE  = 3'd0;
    localparam logic [2:0] ST_PLAYER = 3'd1;
    localparam logic [2:0] ST_PC     = 3'd2;
    localparam logic [2:0] ST_WIN    = 3'd3;
    localparam logic [2:0] ST_LOSE   = 3'd4;

    function automatic logic [H-1:0] popcount(input logic [N-1:0] m);
        logic [H-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + H'(m[i]);
        end
        return c;
    endfunction

    function automatic logic [2*N-1:0] pc_board_init(input logic [N-1:0] m);
        logic [2*N-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            b[2*i +: 2] = m[i] ? 2'd1 : 2'd0;
        end
        return b;
    endfunction

    localparam logic [2*N-1:0] PC_BOARD_INIT = pc_board_init(PC_LAYOUT);
    localparam logic [H-1:0]   PC_HP_INIT    = popcount(PC_LAYOUT);

    logic [7:0]    lfsr;
    logic [7:0]    lfsr_next;
    logic [IW-1:0] probe_idx;
    logic [IW-1:0] probe_next;
    logic [IW-1:0] cand_idx;
    logic [IW-1:0] cur_idx;
    logic [1:0]    cur_cell_pc;
    logic [1:0]    cur_cell_pl;
    logic [1:0]    probe_cell;
    logic [H-1:0]  tgt;
    logic [H-1:0]  placed_hp;
    logic [W-1:0]  mv_x;
    logic [W-1:0]  mv_y;
    logic          free_any;
    logic          timer_expired;

    logic [2:0]    st_n;
    logic          move_en;
    logic          place_en;
    logic          p_shot;
    logic          pc_enter;
    logic          pc_fire;
    logic          probe_step;

    // Taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign cand_idx   = IW'(32'(lfsr_next) % N);
    assign probe_next = (probe_idx == IW'(N - 1)) ? '0 : probe_idx + 1'b1;
    assign cur_idx    = IW'(32'(cursor_y) * GRID + 32'(cursor_x));
    assign cur_cell_pc = matriz_pc[2*cur_idx +: 2];
    assign cur_cell_pl = matriz_player[2*cur_idx +: 2];
    assign probe_cell  = matriz_player[2*probe_idx +: 2];
    assign placed_hp   = (cur_cell_pl == 2'd0) ? hp_player + H'(1) : hp_player;

    always_comb begin
        if (barcos == '0) begin
            tgt = H'(1);
        end else if (32'(barcos) > MAX_SHIPS) begin
            tgt = H'(MAX_SHIPS);
        end else begin
            tgt = H'(barcos);
        end
    end

    // A cell is still a valid PC target while its "attacked" bit (MSB) is 0.
    always_comb begin
        free_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!matriz_player[2*i+1]) begin
                free_any = 1'b1;
            end
        end
    end

    always_comb begin
        mv_x = cursor_x;
        mv_y = cursor_y;
        if (izquierda) begin
            mv_x = (cursor_x == '0) ? W'(GRID - 1) : cursor_x - 1'b1;
        end else if (derecha) begin
            mv_x = (cursor_x == W'(GRID - 1)) ? '0 : cursor_x + 1'b1;
        end else if (arriba) begin
            mv_y = (cursor_y == '0) ? W'(GRID - 1) : cursor_y - 1'b1;
        end else if (abajo) begin
            mv_y = (cursor_y == W'(GRID - 1)) ? '0 : cursor_y + 1'b1;
        end
    end

    always_comb begin
        st_n       = estado;
        move_en    = 1'b0;
        place_en   = 1'b0;
        p_shot     = 1'b0;
        pc_fire    = 1'b0;
        probe_step = 1'b0;
        case (estado)
            ST_PLACE: begin
                move_en = 1'b1;
                if (poner) begin
                    place_en = (cur_cell_pl == 2'd0);
                    if (placed_hp >= tgt) begin
                        st_n = ST_PLAYER;
                    end
                end
            end
            ST_PLAYER: begin
                if (attack && !cur_cell_pc[1]) begin
                    p_shot = 1'b1;
                    st_n   = (cur_cell_pc[0] && hp_pc <= H'(1)) ? ST_WIN : ST_PC;
                end else begin
                    move_en = !attack;
                    if (timer_expired) begin
                        st_n = ST_PC;
                    end
                end
            end
            ST_PC: begin
                if (!free_any) begin
                    st_n = ST_WIN;
                end else if (!probe_cell[1]) begin
                    pc_fire = 1'b1;
                    st_n    = (probe_cell[0] && hp_player <= H'(1)) ? ST_LOSE : ST_PLAYER;
                end else begin
                    probe_step = 1'b1;
                end
            end
            default: ;
        endcase
        pc_enter = (st_n == ST_PC) && (estado != ST_PC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado        <= ST_PLACE;
            cursor_x      <= '0;
            cursor_y      <= '0;
            pc_shot_x     <= '0;
            pc_shot_y     <= '0;
            matriz_player <= '0;
            matriz_pc     <= PC_BOARD_INIT;
            hp_player     <= '0;
            hp_pc         <= PC_HP_INIT;
            win           <= 1'b0;
            lose          <= 1'b0;
            lfsr          <= LFSR_SEED;
            probe_idx     <= '0;
        end else begin
            estado <= st_n;
            if (st_n == ST_WIN) begin
                win <= 1'b1;
            end
            if (st_n == ST_LOSE) begin
                lose <= 1'b1;
            end
            if (move_en) begin
                cursor_x <= mv_x;
                cursor_y <= mv_y;
            end
            if (place_en) begin
                matriz_player[2*cur_idx +: 2] <= 2'd1;
                hp_player <= hp_player + 1'b1;
            end
            if (p_shot) begin
                matriz_pc[2*cur_idx +: 2] <= cur_cell_pc[0] ? 2'd2 : 2'd3;
                if (cur_cell_pc[0] && hp_pc != '0) begin
                    hp_pc <= hp_pc - 1'b1;
                end
            end
            // The first candidate comes from the advanced LFSR, so the shot
            // can land one cycle after entering PC.
            if (pc_enter) begin
                lfsr      <= lfsr_next;
                probe_idx <= cand_idx;
            end
            if (probe_step) begin
                probe_idx <= probe_next;
            end
            if (pc_fire) begin
                matriz_player[2*probe_idx +: 2] <= probe_cell[0] ? 2'd2 : 2'd3;
                if (probe_cell[0] && hp_player != '0) begin
                    hp_player <= hp_player - 1'b1;
                end
                pc_shot_x <= W'(32'(probe_idx) % GRID);
                pc_shot_y <= W'(32'(probe_idx) / GRID);
            end
        end
    end

`ifdef BATTLESHIP_TIMEOUT_EN
    assign timer_expired = (estado == ST_PLAYER) && (turn_timer == 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            turn_timer <= '0;
        end else if (st_n == ST_PLAYER && estado != ST_PLAYER) begin
            turn_timer <= 32'(TIMEOUT_CYCLES);
        end else if (estado == ST_PLAYER && turn_timer != '0) begin
            turn_timer <= turn_timer - 1'b1;
        end
    end
`else
    assign timer_expired = 1'b0;
    assign turn_timer    = '0;

    // Keeps the timeout parameter referenced while the timer is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

endmodule
